// File: rtl/hazard_pkg.sv
// Shared types and legal parameter ranges for the RVX10-P hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        MC_BUSY   = 2'd2
    } hz_state_t;

    localparam int LSC_MIN = 1;
    localparam int LSC_MAX = 3;
    localparam int MCL_MIN = 2;
    localparam int MCL_MAX = 32;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Single-operand EX forwarding select; MEM result wins over WB result.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    output fwd_sel_t          sel
);

    always_comb begin
        sel = FWD_RF;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs))
            sel = FWD_MEM;
        else if (reg_write_w && (rd_w != '0) && (rd_w == rs))
            sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller: load-use and multi-cycle EX interlocks, branch flush,
// forwarding selects and saturating stall/flush counters.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW            = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MC_LATENCY        = 4,
    parameter int CNT_W             = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic              Rs1UsedD,
    input  logic              Rs2UsedD,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              MemReadE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              PCSrcE,
    input  logic              MulStartE,
    input  logic              clear_cnt,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              mc_busy,
    output logic [CNT_W-1:0]  load_stall_cnt,
    output logic [CNT_W-1:0]  mc_stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int WCW     = $clog2(MC_LATENCY) + 1;
    localparam int NUM_OPS = 2;

    generate
        if (LOAD_STALL_CYCLES < LSC_MIN || LOAD_STALL_CYCLES > LSC_MAX ||
            MC_LATENCY < MCL_MIN || MC_LATENCY > MCL_MAX) begin : g_bad_param
            $error("hazard_ctrl_mc: LOAD_STALL_CYCLES or MC_LATENCY out of range");
        end
    endgenerate

    hz_state_t      state_q, state_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           lu_hit;
    logic           ld_stall, mc_stall, br_flush;

    assign lu_hit = MemReadE && (RdE != '0) &&
                    ((Rs1UsedD && (RdE == Rs1D)) || (Rs2UsedD && (RdE == Rs2D)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (PCSrcE) begin
                    state_d = IDLE;
                end else if (lu_hit) begin
                    // A single-bubble load never leaves IDLE.
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = LOAD_WAIT;
                        wcnt_d  = WCW'(LOAD_STALL_CYCLES - 1);
                    end
                end else if (MulStartE) begin
                    state_d = MC_BUSY;
                    wcnt_d  = WCW'(MC_LATENCY - 1);
                end
            end
            LOAD_WAIT, MC_BUSY: begin
                wcnt_d = wcnt_q - 1'b1;
                if (wcnt_q == WCW'(1))
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = '0;
            end
        endcase
    end

    // Stall sources are mutually exclusive by state, so no stage is ever both
    // stalled and flushed.
    always_comb begin
        ld_stall = 1'b0;
        mc_stall = 1'b0;
        br_flush = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (PCSrcE)      br_flush = 1'b1;
                    else if (lu_hit) ld_stall = 1'b1;
                end
                LOAD_WAIT: ld_stall = 1'b1;
                MC_BUSY:   mc_stall = 1'b1;
                default:   ;
            endcase
        end
        stallF  = ld_stall | mc_stall;
        stallD  = ld_stall | mc_stall;
        stallE  = mc_stall;
        flushD  = br_flush;
        flushE  = br_flush | ld_stall;
        flushM  = mc_stall;
        mc_busy = mc_stall;
    end

    logic [NUM_OPS-1:0][REG_AW-1:0] rs_e;
    fwd_sel_t                       fwd_sel [NUM_OPS];

    assign rs_e = {Rs2E, Rs1E};

    generate
        for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
            hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd (
                .rs          (rs_e[i]),
                .rd_m        (RdM),
                .reg_write_m (RegWriteM),
                .rd_w        (RdW),
                .reg_write_w (RegWriteW),
                .sel         (fwd_sel[i])
            );
        end
    endgenerate

    assign ForwardAE = reset ? FWD_RF : fwd_sel[0];
    assign ForwardBE = reset ? FWD_RF : fwd_sel[1];

    always_ff @(posedge clk) begin
        if (reset || clear_cnt) begin
            load_stall_cnt <= '0;
            mc_stall_cnt   <= '0;
            flush_cnt      <= '0;
        end else begin
            if (ld_stall && (load_stall_cnt != '1)) load_stall_cnt <= load_stall_cnt + 1'b1;
            if (mc_stall && (mc_stall_cnt != '1))   mc_stall_cnt   <= mc_stall_cnt + 1'b1;
            if (br_flush && (flush_cnt != '1))      flush_cnt      <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed scoreboard bench: u0 uses L=1/32-bit counters, u1 uses L=3/3-bit counters.
module tb_hazard_ctrl_mc;

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LD   = 7'b1100100;  // {sF,sD,sE,fD,fE,fM,busy}
    localparam logic [6:0] BR   = 7'b0001100;
    localparam logic [6:0] MC   = 7'b1110011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, Rs1UsedD, Rs2UsedD, MemReadE, RegWriteM, RegWriteW;
    logic       PCSrcE, MulStartE, clear_cnt;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;

    logic [1:0]  fa0, fb0, fa1, fb1;
    logic        sF0, sD0, sE0, fD0, fE0, fM0, bz0;
    logic        sF1, sD1, sE1, fD1, fE1, fM1, bz1;
    logic [31:0] lsc0, msc0, fc0;
    logic [2:0]  lsc1, msc1, fc1;

    hazard_ctrl_mc #(.REG_AW(5), .LOAD_STALL_CYCLES(1), .MC_LATENCY(4), .CNT_W(32)) u0 (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1UsedD(Rs1UsedD),
        .Rs2UsedD(Rs2UsedD), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .MemReadE(MemReadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MulStartE(MulStartE), .clear_cnt(clear_cnt), .ForwardAE(fa0), .ForwardBE(fb0),
        .stallF(sF0), .stallD(sD0), .stallE(sE0), .flushD(fD0), .flushE(fE0), .flushM(fM0),
        .mc_busy(bz0), .load_stall_cnt(lsc0), .mc_stall_cnt(msc0), .flush_cnt(fc0));

    hazard_ctrl_mc #(.REG_AW(5), .LOAD_STALL_CYCLES(3), .MC_LATENCY(4), .CNT_W(3)) u1 (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1UsedD(Rs1UsedD),
        .Rs2UsedD(Rs2UsedD), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .MemReadE(MemReadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MulStartE(MulStartE), .clear_cnt(clear_cnt), .ForwardAE(fa1), .ForwardBE(fb1),
        .stallF(sF1), .stallD(sD1), .stallE(sE1), .flushD(fD1), .flushE(fE1), .flushM(fM1),
        .mc_busy(bz1), .load_stall_cnt(lsc1), .mc_stall_cnt(msc1), .flush_cnt(fc1));

    typedef struct {
        string      name;
        int         dut;
        logic [6:0] ctl;
        logic [1:0] fa, fb;
        bit         chk;
        int         lsc, msc, fc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk)
        assert (!(MulStartE && MemReadE)) else $error("illegal MulStartE with MemReadE");

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [6:0]  act;
        logic [1:0]  afa, afb;
        logic [31:0] al, am, af;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.dut == 0) begin
                act = {sF0, sD0, sE0, fD0, fE0, fM0, bz0};
                afa = fa0; afb = fb0; al = lsc0; am = msc0; af = fc0;
            end else begin
                act = {sF1, sD1, sE1, fD1, fE1, fM1, bz1};
                afa = fa1; afb = fb1;
                al = {29'd0, lsc1}; am = {29'd0, msc1}; af = {29'd0, fc1};
            end
            tests++;
            if (act !== e.ctl) begin
                fails++;
                $display("FAIL %s ctl got %b want %b", e.name, act, e.ctl);
            end
            tests++;
            if ({afa, afb} !== {e.fa, e.fb}) begin
                fails++;
                $display("FAIL %s fwd got A=%b B=%b want A=%b B=%b", e.name, afa, afb, e.fa, e.fb);
            end
            if (e.chk) begin
                tests++;
                if (al !== 32'(e.lsc) || am !== 32'(e.msc) || af !== 32'(e.fc)) begin
                    fails++;
                    $display("FAIL %s cnt got %0d/%0d/%0d want %0d/%0d/%0d",
                             e.name, al, am, af, e.lsc, e.msc, e.fc);
                end
            end
        end
    end

    task automatic idle();
        reset = 0; Rs1D = 0; Rs2D = 0; Rs1UsedD = 0; Rs2UsedD = 0; Rs1E = 0; Rs2E = 0;
        RdE = 0; RdM = 0; RdW = 0; MemReadE = 0; RegWriteM = 0; RegWriteW = 0;
        PCSrcE = 0; MulStartE = 0; clear_cnt = 0;
    endtask

    task automatic hazard(input logic [4:0] rd);
        idle(); MemReadE = 1; RdE = rd; Rs1D = rd; Rs1UsedD = 1;
    endtask

    task automatic step(input string nm, input int dut, input logic [6:0] ctl,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input bit chk, input int l, input int m, input int f);
        exp_t e;
        e.name = nm; e.dut = dut; e.ctl = ctl; e.fa = fa; e.fb = fb;
        e.chk = chk; e.lsc = l; e.msc = m; e.fc = f;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    initial begin
        idle(); reset = 1;
        @(posedge clk); #1;
        // reset gates live hazard and forwarding conditions
        hazard(5); reset = 1; RdM = 7; RegWriteM = 1; Rs1E = 7;
        step("rst_gate0", 0, NONE, 2'b00, 2'b00, 1, 0, 0, 0);
        step("rst_gate1", 1, NONE, 2'b00, 2'b00, 1, 0, 0, 0);

        hazard(5);                                   step("lu_rs1",     0, LD,   0, 0, 1, 0, 0, 0);
        idle();                                      step("lu_rel",     0, NONE, 0, 0, 1, 1, 0, 0);
        hazard(0);                                   step("lu_x0",      0, NONE, 0, 0, 1, 1, 0, 0);
        hazard(5); Rs1UsedD = 0; Rs2D = 5;           step("lu_unused",  0, NONE, 0, 0, 1, 1, 0, 0);
        Rs2UsedD = 1;                                step("lu_rs2",     0, LD,   0, 0, 1, 1, 0, 0);
        idle();                                      step("lu_rs2_rel", 0, NONE, 0, 0, 1, 2, 0, 0);
        hazard(5); PCSrcE = 1;                       step("br_over_lu", 0, BR,   0, 0, 1, 2, 0, 0);
        idle();                                      step("br_rel",     0, NONE, 0, 0, 1, 2, 0, 1);

        idle(); MulStartE = 1;                       step("mc_start",   0, NONE, 0, 0, 1, 2, 0, 1);
        idle(); RdM = 3; RegWriteM = 1; Rs1E = 3;    step("mc_busy1",   0, MC, 2'b10, 0, 1, 2, 0, 1);
        hazard(5); PCSrcE = 1;                       step("mc_busy2",   0, MC,   0, 0, 1, 2, 1, 1);
        idle(); MulStartE = 1;                       step("mc_busy3",   0, MC,   0, 0, 1, 2, 2, 1);
        idle();                                      step("mc_rel",     0, NONE, 0, 0, 1, 2, 3, 1);

        idle(); RdM = 7; RdW = 7; Rs1E = 7; RegWriteM = 1; RegWriteW = 1;
        step("fwd_mem", 0, NONE, 2'b10, 2'b00, 0, 0, 0, 0);
        RegWriteM = 0;
        step("fwd_wb",  0, NONE, 2'b01, 2'b00, 0, 0, 0, 0);
        Rs1E = 0; RdM = 0; RdW = 0; RegWriteM = 1;
        step("fwd_x0",  0, NONE, 2'b00, 2'b00, 0, 0, 0, 0);
        idle(); Rs1E = 4; Rs2E = 9; RdM = 9; RdW = 9; RegWriteM = 1; RegWriteW = 1;
        step("fwd_b_mem", 0, NONE, 2'b00, 2'b10, 0, 0, 0, 0);
        Rs1E = 9; RdM = 8;
        step("fwd_b_wb",  0, NONE, 2'b01, 2'b01, 0, 0, 0, 0);

        idle(); PCSrcE = 1; clear_cnt = 1;           step("clr_br",     0, BR,   0, 0, 1, 2, 3, 1);
        idle();                                      step("clr_done",   0, NONE, 0, 0, 1, 0, 0, 0);

        idle(); MulStartE = 1;                       step("mc2_start",  0, NONE, 0, 0, 1, 0, 0, 0);
        idle();                                      step("mc2_busy1",  0, MC,   0, 0, 1, 0, 0, 0);
        idle(); reset = 1;                           step("mc2_rst",    0, NONE, 0, 0, 0, 0, 0, 0);
        idle();                                      step("mc2_idle",   0, NONE, 0, 0, 1, 0, 0, 0);
        hazard(5);                                   step("mc2_lu",     0, LD,   0, 0, 1, 0, 0, 0);

        idle(); reset = 1;                           step("b_rst",      1, NONE, 0, 0, 0, 0, 0, 0);
        hazard(5);                                   step("b_lu",       1, LD,   0, 0, 1, 0, 0, 0);
        idle();                                      step("b_w1",       1, LD,   0, 0, 1, 1, 0, 0);
        idle(); PCSrcE = 1;                          step("b_w2_br",    1, LD,   0, 0, 1, 2, 0, 0);
        idle();                                      step("b_rel",      1, NONE, 0, 0, 1, 3, 0, 0);
        hazard(6);                                   step("b_lu2",      1, LD,   0, 0, 1, 3, 0, 0);
        idle();                                      step("b_w3",       1, LD,   0, 0, 1, 4, 0, 0);
        idle();                                      step("b_w4",       1, LD,   0, 0, 1, 5, 0, 0);
        idle();                                      step("b_rel2",     1, NONE, 0, 0, 1, 6, 0, 0);
        hazard(6);                                   step("b_lu3",      1, LD,   0, 0, 1, 6, 0, 0);
        idle();                                      step("b_w5",       1, LD,   0, 0, 1, 7, 0, 0);
        idle();                                      step("b_w6_sat",   1, LD,   0, 0, 1, 7, 0, 0);
        idle();                                      step("b_sat",      1, NONE, 0, 0, 1, 7, 0, 0);
        hazard(0);                                   step("b_x0",       1, NONE, 0, 0, 1, 7, 0, 0);
        idle(); clear_cnt = 1;                       step("b_clr",      1, NONE, 0, 0, 1, 7, 0, 0);
        idle();                                      step("b_clr_done", 1, NONE, 0, 0, 1, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain %0d records left want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
